// File: rtl/serial_add_pkg.sv
// Shared types and sizing helpers for the bit-serial adder sequencer.
// Optional subtract mode is enabled by defining SERIAL_ADD_SUB_EN.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } sa_state_t;

  localparam int SA_MIN_WIDTH = 2;
  localparam int SA_MAX_WIDTH = 32;

  // Counter must reach WIDTH-1, so $clog2(WIDTH) bits suffice.
  function automatic int cnt_width(input int width);
    return (width < SA_MIN_WIDTH) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_fa_bit.sv
// One-bit full adder with its carry flop; the flop can be cleared,
// preloaded with a carry-in, or advanced by one serial step.
module serial_fa_bit (
  input  logic clk,
  input  logic clr,
  input  logic load,
  input  logic en,
  input  logic cin,
  input  logic a,
  input  logic b,
  output logic s,
  output logic carry
);

  logic carry_next;

  assign s          = a ^ b ^ carry;
  assign carry_next = (a & b) | (a & carry) | (b & carry);

  always_ff @(posedge clk) begin
    if (clr) begin
      carry <= 1'b0;
    end else if (load) begin
      carry <= cin;
    end else if (en) begin
      carry <= carry_next;
    end
  end

endmodule

// File: rtl/serial_add_seq.sv
// Sequencer wrapping a bit-serial adder: loads parallel operands on start,
// shifts LSB-first for WIDTH cycles, then pulses done. Macro: SERIAL_ADD_SUB_EN.
import serial_add_pkg::*;

module serial_add_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  sa_state_t        state;
  sa_state_t        next_state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             shifting;
  logic             last;
  logic             fa_s;
  logic             carry;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;

`ifdef SERIAL_ADD_SUB_EN
  // Subtraction is A + ~B + 1, so invert B and seed the carry with 1.
  assign b_load     = sub ? ~b : b;
  assign carry_load = sub;
`else
  assign b_load     = b;
  assign carry_load = 1'b0;
`endif

  assign last     = (cnt == LAST_CNT);
  assign shifting = (state == SHIFT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Start is only honoured in IDLE or DONE; the 2'b11 encoding falls back to IDLE.
  always_comb begin
    next_state = IDLE;
    accept     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        accept     = start;
        next_state = start ? SHIFT : IDLE;
      end
      SHIFT: begin
        busy       = 1'b1;
        next_state = last ? DONE : SHIFT;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        accept     = start;
        next_state = start ? SHIFT : IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      cnt    <= '0;
    end else if (accept) begin
      a_sr   <= a;
      b_sr   <= b_load;
      sum_sr <= '0;
      cnt    <= '0;
    end else if (shifting) begin
      a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
      sum_sr <= {fa_s, sum_sr[WIDTH-1:1]};
      cnt    <= cnt + CW'(1);
    end
  end

  serial_fa_bit u_fa (
    .clk   (clk),
    .clr   (rst),
    .load  (accept),
    .en    (shifting),
    .cin   (carry_load),
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .s     (fa_s),
    .carry (carry)
  );

  assign sum  = sum_sr;
  assign cout = carry;

endmodule

// File: tb/tb_serial_add_seq.sv
// Directed self-checking bench for serial_add_seq (WIDTH=4); covers the
// subtract mode too when SERIAL_ADD_SUB_EN is defined.
module tb_serial_add_seq;

  localparam int WIDTH = 4;
  localparam int MAX_WAIT = 20;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int errors;
  int checks;
  int cycles;
  int done_seen;

  serial_add_seq #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Drives one start pulse on the next edge; returns at the negedge after it.
  task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                               input logic subv);
    start = 1'b1;
    a     = av;
    b     = bv;
    sub   = subv;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a     = '0;
    b     = '0;
    sub   = 1'b0;
  endtask

  // Counts edges since the accepting edge until done is seen (bounded).
  task automatic waitDone(input int already);
    cycles = already;
    done_seen = 0;
    while (!done && cycles < MAX_WAIT) begin
      @(posedge clk);
      @(negedge clk);
      cycles++;
    end
    if (done) done_seen = 1;
  endtask

  task automatic runOp(input string tag, input logic [WIDTH-1:0] av,
                       input logic [WIDTH-1:0] bv, input logic subv,
                       input logic [WIDTH-1:0] exp_sum, input logic exp_cout);
    applyStimulus(av, bv, subv);
    checkOutput({tag, "_busy"}, busy, 1);
    waitDone(1);
    checkOutput({tag, "_latency"}, cycles, 5);
    checkOutput({tag, "_sum"}, sum, exp_sum);
    checkOutput({tag, "_cout"}, cout, exp_cout);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    sub    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("idle_busy", busy, 0);
      checkOutput("idle_done", done, 0);
      checkOutput("idle_sum", sum, 0);
      checkOutput("idle_cout", cout, 0);
    end

    // 1010 + 0011 = 1101, then result must hold while idle.
    runOp("add1", 4'b1010, 4'b0011, 1'b0, 4'b1101, 1'b0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("add1_done_pulse", done, 0);
    checkOutput("add1_idle_busy", busy, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("add1_hold_sum", sum, 4'b1101);
    checkOutput("add1_hold_cout", cout, 0);

    // 1111 + 0001 overflows, then back-to-back restart from DONE.
    runOp("add2", 4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1);
    runOp("b2b", 4'b0110, 4'b0111, 1'b0, 4'b1101, 1'b0);
    @(posedge clk);
    @(negedge clk);

    // Start during SHIFT is ignored; exactly one done results.
    applyStimulus(4'b1010, 4'b0011, 1'b0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    a     = 4'b0111;
    b     = 4'b0111;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    waitDone(3);
    checkOutput("ign_latency", cycles, 5);
    checkOutput("ign_sum", sum, 4'b1101);
    checkOutput("ign_cout", cout, 0);
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) done_seen++;
    end
    checkOutput("ign_extra_done", done_seen, 0);

    // Reset mid-shift with start held high; start after release works.
    applyStimulus(4'b1111, 4'b1111, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    a     = 4'b0101;
    b     = 4'b0100;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_sum", sum, 0);
    checkOutput("rst_cout", cout, 0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checkOutput("post_rst_busy", busy, 1);
    waitDone(1);
    checkOutput("post_rst_latency", cycles, 5);
    checkOutput("post_rst_sum", sum, 4'b1001);
    checkOutput("post_rst_cout", cout, 0);
    @(posedge clk);
    @(negedge clk);

`ifdef SERIAL_ADD_SUB_EN
    runOp("sub1", 4'b0011, 4'b0101, 1'b1, 4'b1110, 1'b0);
    runOp("sub2", 4'b0101, 4'b0011, 1'b1, 4'b0010, 1'b1);
    @(posedge clk);
    @(negedge clk);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_add_seq.md
# serial_add_seq

Sequencer for a bit-serial ripple adder: accepts two parallel operands on a start pulse, loads them into right-shift registers, and steps the serial full-adder/carry flop LSB-first for exactly WIDTH cycles. It then presents the parallel sum and carry-out with a one-cycle done pulse. It is the control wrapper that makes the serial shift-register adder usable by parallel-bus logic without a testbench hand-driving `shift_ctrl`.

## Interface
Parameters:
- `WIDTH`, 4, operand/sum width in bits; legal range 2..32.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  request an operation; sampled only in IDLE or DONE.
- `a`  in  WIDTH  operand A; sampled on the accepting edge only.
- `b`  in  WIDTH  operand B; sampled on the accepting edge only.
- `sub`  in  1  1 = A−B, 0 = A+B; present only with `SERIAL_ADD_SUB_EN`.
- `busy`  out  1  high in SHIFT and DONE.
- `done`  out  1  one-cycle pulse in DONE.
- `sum`  out  WIDTH  result shift register contents.
- `cout`  out  1  carry flop contents.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE, start=1: load `a_sr<=a`, `b_sr<=b`, carry<=0, `sum_sr<=0`, cnt<=0, go SHIFT. With start=0: hold.
- SHIFT, every edge:
  - s = a_sr[0]^b_sr[0]^c; carry <= majority(a_sr[0], b_sr[0], c).
  - a_sr, b_sr shift right, with 0 into the MSB.
  - sum_sr <= {s, sum_sr[WIDTH-1:1]}.
  - cnt++.
  - The edge where cnt==WIDTH-1 goes to DONE.
- DONE: done=1. start=1 is accepted exactly as in IDLE (back-to-back). Otherwise go IDLE.
- start in SHIFT is ignored, with no queuing.
- `sum`/`cout` are intermediate during SHIFT. From entry into DONE they hold the final A+B mod 2^WIDTH and carry-out until the next accepting edge.
- Arithmetic is unsigned. `cout` is the carry out of bit WIDTH-1.
- Reset (any state, including mid-SHIFT): state=IDLE, all shift registers, cnt, and carry cleared. busy=0, done=0, sum=0, cout=0. The aborted operation produces no done.
- Reset takes priority over start on the same edge.

## Timing
- Start accepted at edge E0; shifts occur at E1..E_WIDTH; done is high for the cycle after E_WIDTH.
- Latency from start sample to done = WIDTH+1 cycles.
- busy rises in the cycle after E0 and stays high through DONE.
- Peak throughput is one operation per WIDTH+1 cycles, with start held or re-asserted during DONE.
- No combinational path from inputs to outputs. All outputs are registered or decoded from the state register.

## Configuration
- `SERIAL_ADD_SUB_EN` defined:
  - The `sub` port exists and is sampled with `a`/`b`.
  - sub=1 loads `b_sr<=~b` and carry<=1, giving two's-complement A−B.
  - `cout`=1 means no borrow (A≥B unsigned).
  - sub=0 behaves as add.
- Undefined: no `sub` port; carry always loads 0; add only.

## Structure
- Package `serial_add_pkg`:
  - state typedef `sa_state_t` {IDLE=2'b00, SHIFT=2'b01, DONE=2'b10};
  - count width constant/function `$clog2(WIDTH)`;
  - unused encoding 2'b11 decodes to IDLE.
- Sub-module `serial_fa_bit`: combinational full adder plus carry flop with synchronous `clr`/`load` (load value = carry-in). Instantiated once.
- Top module contains the FSM, counter, and the three shift registers.

## Test plan
- Reset, then idle 3 cycles -> busy=0, done=0, sum=0, cout=0 throughout.
- WIDTH=4, a=4'b1010, b=4'b0011, start 1 cycle -> done exactly 5 cycles after the start edge; sum=4'b1101, cout=0; held until next start.
- a=4'b1111, b=4'b0001 -> sum=4'b0000, cout=1. Immediately restart in DONE with a=4'b0110, b=4'b0111 -> second done 5 cycles later, sum=4'b1101, cout=0, no IDLE cycle in between.
- start pulsed at cycle 2 of SHIFT with different operands -> ignored; result matches the first operands; only one done.
- rst asserted at shift 2 of an operation, start held high through reset -> outputs 0 the cycle after reset; no done. First start after rst deasserts is accepted normally.
- `SERIAL_ADD_SUB_EN`: a=4'b0011, b=4'b0101, sub=1 -> sum=4'b1110, cout=0. a=4'b0101, b=4'b0011, sub=1 -> sum=4'b0010, cout=1.
